frame_uart_streamer: RTL
========================

// Module: frame_uart_streamer
// PURPOSE
// Parametrised frame-readout controller between line_buffer and uart_send/uart_receive. A command byte
// starts a frame readout: optional 4-byte header, then pixels line by line, with decimation 1/2/4
// and 8-bit or 16-bit pixel packing. Supports abort, a frame counter and a done pulse.
// PARAMETERS
// H      752    active columns per line
// V      480    lines per frame
// DW     10     pixel width from line_buffer (8..16)
// SYNC0  8'hA5  header byte 0
// SYNC1  8'h5A  header byte 1
// PORTS
// CLK         in   1           system clock
// RST_N       in   1           asynchronous reset, active-low
// CMD_DATA    in   8           received byte: [1:0] log2 decimation (3 = 2), [2] header en, [3] abort, [4] 16-bit mode
// CMD_VALID   in   1           1-cycle strobe, CMD_DATA valid
// LINE_READY  in   1           line_buffer holds the whole of LINE_SEL
// PIX_DATA    in   DW          line_buffer read data, valid 1 cycle after COL_ADDR
// TX_IDLE     in   1           uart_send idle
// LINE_SEL    out  clog2(V)    requested line
// COL_ADDR    out  clog2(H)    line_buffer read address
// LINE_REL    out  1           1-cycle pulse: release the buffer and re-arm capture
// TX_DATA     out  8           byte to uart_send
// TX_VALID    out  1           1-cycle send strobe
// BUSY        out  1           frame in progress
// FRAME_DONE  out  1           1-cycle pulse after the last byte of a complete frame
// FRAME_CNT   out  8           completed frames, wraps 255->0
// BEHAVIOUR
// - Reset (async, RST_N=0): every output is 0 and the state is IDLE. Applying reset mid-frame drops everything at once.
// - States: IDLE, HDR, WAIT_LINE, FETCH, SEND_HI, SEND_LO, WAIT_TX, EOL.
// - IDLE: CMD_VALID with [3]=0 latches mode (step S=1<<min(CMD[1:0],2), hdr, w16).
//   LINE_SEL=0 and COL_ADDR=0, BUSY=1. Next state is HDR if hdr, else WAIT_LINE. CMD_VALID with [3]=1 in IDLE is ignored.
// - HDR: send SYNC0, SYNC1, FRAME_CNT, then mode byte {4'b0,w16,hdr,CMD[1:0]}. Each byte goes through WAIT_TX.
// - TX rule: TX_VALID is issued only in a cycle with TX_IDLE=1. WAIT_TX ignores TX_IDLE in the next cycle,
//   then waits for TX_IDLE=1. uart_send deasserts IDLE within 1 cycle.
// - WAIT_LINE: wait for LINE_READY=1, then go to FETCH. COL_ADDR is presented and PIX_DATA is registered the cycle after.
// - 8-bit mode: one byte, PIX_DATA[DW-1:DW-8].
// - w16 mode (forced off when DW=8): SEND_HI sends zero-padded PIX_DATA[DW-1:8], then SEND_LO sends PIX_DATA[7:0].
// - Column advance: compute col+S at clog2(H)+1 bits. If < H, COL_ADDR<=col+S and go to FETCH; else go to EOL.
// - EOL: LINE_REL pulses 1 cycle and COL_ADDR<=0. Compute line+S at clog2(V)+1 bits. If < V, LINE_SEL<=line+S
//   and go to WAIT_LINE. Else FRAME_CNT++, FRAME_DONE pulses, BUSY=0, LINE_SEL<=0, and go to IDLE.
// - Output size: ceil(H/S) x ceil(V/S) pixels. Lines and columns not divisible by S are skipped, never read.
// - Abort (CMD_VALID with [3]=1 while BUSY):
//   - Abort is latched. The byte in flight (incl. the lo byte of a w16 pair) completes.
//   - Then LINE_REL pulses once, BUSY=0 and the state returns to IDLE.
//   - There is no FRAME_DONE and FRAME_CNT is unchanged.
// - A non-abort CMD_VALID while BUSY is ignored. An abort arriving in the same cycle as the last EOL is ignored and the frame completes.
// - LINE_READY dropping mid-line is not checked. The line_buffer owns that contract.
// STRUCTURE
// - Shared package cam_pkg: the state enum, the CMD bit positions (CMD_DEC, CMD_HDR, CMD_ABORT, CMD_W16),
//   and the SYNC defaults.
// - Sub-module tx_byte_gate: owns the TX_VALID/TX_IDLE handshake and the 1-cycle ignore window, and reports byte_done.
//   The FSM, counters and decimation live in the top.
// TESTING (H=8, V=4, DW=10, line_buffer model returns {line,col}-derived data, UART model idle drops 1 cycle after TX_VALID, busy 10 cycles)
// 1. CMD=8'h00 -> 32 bytes = PIX[9:2] in raster order, 4 LINE_REL pulses, FRAME_DONE once, FRAME_CNT 0->1.
// 2. CMD=8'h05 (S=2, hdr) -> A5,5A,00,05 then 4x2=8 pixels (cols 0,2,4,6; lines 0,2), 2 LINE_REL pulses.
// 3. CMD=8'h12 (S=4, w16) -> 2 pixels x 2 bytes: hi=000000PP[9:8], lo=PP[7:0], in hi-then-lo order.
// 4. Abort 8'h08 between the hi and lo bytes -> lo byte still sent, 1 LINE_REL, BUSY=0, no FRAME_DONE, FRAME_CNT held.
// 5. LINE_READY held low for 50 cycles after the first LINE_REL -> no TX_VALID until it rises, then line 1 streams correctly.
// 6. RST_N low mid-frame -> all outputs 0 immediately. The next CMD restarts at line 0, col 0, with FRAME_CNT=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the frame readout path: FSM states, command
// byte fields and default header sync bytes.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WAIT_LINE,
    FETCH,
    SEND_HI,
    SEND_LO,
    WAIT_TX,
    EOL
  } state_t;

  localparam int unsigned CMD_DEC   = 0;  // two bits, [CMD_DEC +: 2]
  localparam int unsigned CMD_HDR   = 2;
  localparam int unsigned CMD_ABORT = 3;
  localparam int unsigned CMD_W16   = 4;

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;

  // log2 decimation of 3 saturates to a step of 4
  function automatic logic [2:0] dec_step(input logic [1:0] dec);
    logic [2:0] s;
    if (dec >= 2'd2)      s = 3'd4;
    else if (dec == 2'd1) s = 3'd2;
    else                  s = 3'd1;
    return s;
  endfunction

endpackage

// File: rtl/tx_byte_gate.sv
// Byte handshake towards uart_send: strobes only while the UART is idle and
// masks the cycle right after a strobe, before the UART has dropped idle.
module tx_byte_gate (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_req,
  input  logic [7:0] byte_in,
  input  logic       wait_tx,
  input  logic       tx_idle,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       byte_done
);

  logic ignore_q;

  always_comb begin
    tx_valid  = send_req & tx_idle;
    tx_data   = tx_valid ? byte_in : '0;
    byte_done = wait_tx & ~ignore_q & tx_idle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ignore_q <= 1'b0;
    else        ignore_q <= tx_valid;
  end

endmodule

// File: rtl/frame_uart_streamer.sv
// Frame readout controller: walks line_buffer with decimation, packs pixels
// into UART bytes with an optional header, and handles abort and frame count.
module frame_uart_streamer
  import cam_pkg::*;
#(
  parameter int unsigned H     = 752,
  parameter int unsigned V     = 480,
  parameter int unsigned DW    = 10,
  parameter logic [7:0]  SYNC0 = SYNC0_DEF,
  parameter logic [7:0]  SYNC1 = SYNC1_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [7:0]           CMD_DATA,
  input  logic                 CMD_VALID,
  input  logic                 LINE_READY,
  input  logic [DW-1:0]        PIX_DATA,
  input  logic                 TX_IDLE,
  output logic [$clog2(V)-1:0] LINE_SEL,
  output logic [$clog2(H)-1:0] COL_ADDR,
  output logic                 LINE_REL,
  output logic [7:0]           TX_DATA,
  output logic                 TX_VALID,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output logic [7:0]           FRAME_CNT
);

  localparam int unsigned CW     = $clog2(H);
  localparam int unsigned LW     = $clog2(V);
  localparam logic        W16_OK = (DW > 8);

  state_t        state_q, state_d, from_q, from_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [2:0]    step_q, step_d;
  logic [1:0]    dec_q, dec_d, hdr_idx_q, hdr_idx_d;
  logic          hdr_q, hdr_d, w16_q, w16_d, abort_q, abort_d, ph_q, ph_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   pix_ext;
  logic [CW:0]   col_nxt;
  logic [LW:0]   line_nxt;
  logic          abort_in, abort_any, send_req, byte_done, cmd_unused;
  logic [7:0]    tx_byte;

  assign abort_in   = CMD_VALID & CMD_DATA[CMD_ABORT];
  assign abort_any  = abort_q | abort_in;
  assign pix_ext    = 16'(pix_q);
  assign col_nxt    = {1'b0, col_q} + (CW+1)'(step_q);
  assign line_nxt   = {1'b0, line_q} + (LW+1)'(step_q);
  assign cmd_unused = ^CMD_DATA[7:5];

  assign LINE_SEL  = line_q;
  assign COL_ADDR  = col_q;
  assign BUSY      = (state_q != IDLE);
  assign FRAME_CNT = cnt_q;

  tx_byte_gate u_gate (
    .clk      (CLK),
    .rst_n    (RST_N),
    .send_req (send_req),
    .byte_in  (tx_byte),
    .wait_tx  (state_q == WAIT_TX),
    .tx_idle  (TX_IDLE),
    .tx_data  (TX_DATA),
    .tx_valid (TX_VALID),
    .byte_done(byte_done)
  );

  // Kept apart from the next-state logic so TX_VALID feeds back without a loop.
  // A pending abort suppresses a new byte, except the lo half of a w16 pair.
  always_comb begin
    send_req = 1'b0;
    tx_byte  = '0;
    case (state_q)
      HDR: begin
        send_req = ~abort_any;
        case (hdr_idx_q)
          2'd0:    tx_byte = SYNC0;
          2'd1:    tx_byte = SYNC1;
          2'd2:    tx_byte = cnt_q;
          default: tx_byte = {4'b0000, w16_q, hdr_q, dec_q};
        endcase
      end
      SEND_HI: begin
        send_req = ~abort_any;
        tx_byte  = pix_ext[15:8];
      end
      SEND_LO: begin
        send_req = w16_q | ~abort_any;
        tx_byte  = w16_q ? pix_ext[7:0] : pix_q[DW-1 -: 8];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    from_d     = from_q;
    line_d     = line_q;
    col_d      = col_q;
    step_d     = step_q;
    dec_d      = dec_q;
    hdr_d      = hdr_q;
    w16_d      = w16_q;
    hdr_idx_d  = hdr_idx_q;
    abort_d    = abort_q | (abort_in & (state_q != IDLE));
    ph_d       = 1'b0;
    pix_d      = pix_q;
    cnt_d      = cnt_q;
    LINE_REL   = 1'b0;
    FRAME_DONE = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (CMD_VALID && !CMD_DATA[CMD_ABORT]) begin
          dec_d     = CMD_DATA[CMD_DEC +: 2];
          step_d    = dec_step(CMD_DATA[CMD_DEC +: 2]);
          hdr_d     = CMD_DATA[CMD_HDR];
          w16_d     = CMD_DATA[CMD_W16] & W16_OK;
          line_d    = '0;
          col_d     = '0;
          hdr_idx_d = '0;
          state_d   = CMD_DATA[CMD_HDR] ? HDR : WAIT_LINE;
        end
      end
      HDR: begin
        if (abort_any) state_d = EOL;
        else if (TX_VALID) begin
          from_d    = HDR;
          hdr_idx_d = hdr_idx_q + 2'd1;
          state_d   = WAIT_TX;
        end
      end
      WAIT_LINE: begin
        if (abort_any)       state_d = EOL;
        else if (LINE_READY) state_d = FETCH;
      end
      FETCH: begin
        // phase 0 presents COL_ADDR, phase 1 captures the returned pixel
        if (abort_any) state_d = EOL;
        else if (!ph_q) ph_d = 1'b1;
        else begin
          pix_d   = PIX_DATA;
          state_d = w16_q ? SEND_HI : SEND_LO;
        end
      end
      SEND_HI: begin
        if (abort_any) state_d = EOL;
        else if (TX_VALID) begin
          from_d  = SEND_HI;
          state_d = WAIT_TX;
        end
      end
      SEND_LO: begin
        if (abort_any && !w16_q) state_d = EOL;
        else if (TX_VALID) begin
          from_d  = SEND_LO;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (byte_done) begin
          case (from_q)
            HDR: begin
              if (abort_any)              state_d = EOL;
              else if (hdr_idx_q == 2'd0) state_d = WAIT_LINE;
              else                        state_d = HDR;
            end
            SEND_HI: state_d = SEND_LO;
            default: begin
              if (abort_any) state_d = EOL;
              else if (col_nxt < (CW+1)'(H)) begin
                col_d   = col_nxt[CW-1:0];
                state_d = FETCH;
              end else state_d = EOL;
            end
          endcase
        end
      end
      EOL: begin
        LINE_REL = 1'b1;
        col_d    = '0;
        if (!(line_nxt < (LW+1)'(V)) && !abort_q) begin
          cnt_d      = cnt_q + 8'd1;
          FRAME_DONE = 1'b1;
          line_d     = '0;
          abort_d    = 1'b0;
          state_d    = IDLE;
        end else if (abort_any) begin
          line_d  = '0;
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          line_d  = line_nxt[LW-1:0];
          state_d = WAIT_LINE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      from_q    <= IDLE;
      line_q    <= '0;
      col_q     <= '0;
      step_q    <= 3'd1;
      dec_q     <= '0;
      hdr_q     <= 1'b0;
      w16_q     <= 1'b0;
      hdr_idx_q <= '0;
      abort_q   <= 1'b0;
      ph_q      <= 1'b0;
      pix_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      from_q    <= from_d;
      line_q    <= line_d;
      col_q     <= col_d;
      step_q    <= step_d;
      dec_q     <= dec_d;
      hdr_q     <= hdr_d;
      w16_q     <= w16_d;
      hdr_idx_q <= hdr_idx_d;
      abort_q   <= abort_d;
      ph_q      <= ph_d;
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
